ifu_fetch_ysyx23060136: RTL and testbench
=========================================

# ifu_fetch_ysyx23060136

Instruction fetch unit of the RV32E pipeline: holds the PC, issues one read per instruction on the instruction-memory read channel, and presents each fetched word with its PC to the decode stage through a valid/ready handshake. Jump/branch/trap redirects from the execute stage flush any in-flight fetch and restart at the target. It is the producing end of the decode stage's instruction input.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  flush and restart fetch (jump taken, branch taken, ecall, mret)
- redirect_pc  in  32  restart target; bits [1:0] ignored (treated as 00)
- ifu_arvalid  out  1  read-address valid
- ifu_araddr  out  32  read address (word aligned)
- ifu_arready  in  1  memory accepts address
- ifu_rvalid  in  1  read data valid
- ifu_rdata  in  32  instruction word
- ifu_rresp  in  2  2'b00 OKAY, anything else = access fault
- ifu_rready  out  1  fetch ready for read data
- IFU_valid  out  1  instruction/PC valid toward decode
- IFU_inst  out  32  instruction word (32'h0000_0013, addi x0,x0,0, when faulted)
- IFU_pc  out  32  PC of IFU_inst
- IFU_fault  out  1  instruction access fault for this PC
- IDU_ready  in  1  decode accepts current instruction

## Operation
- States: S_IDLE, S_ADDR, S_DATA, S_OUT. Reset enters S_IDLE; S_IDLE -> S_ADDR unconditionally next cycle.
- S_ADDR: ifu_arvalid=1, ifu_araddr=pc. On arvalid&arready -> S_DATA. Address and arvalid held stable until accepted.
- S_DATA: ifu_rready=1. On rvalid: if discard flag clear, capture rdata/rresp/pc into output registers -> S_OUT; if set, drop the data, clear discard -> S_ADDR.
- S_OUT: IFU_valid=1, outputs stable. On IFU_valid&IDU_ready: pc <= pc+4 -> S_ADDR.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (pc <= {redirect_pc[31:2],2'b00}) by state:
  - S_IDLE: load pc, go to S_ADDR as normal.
  - S_ADDR before acceptance: address already committed; stay, set discard, load pc. If arready in same cycle: go S_DATA with discard set.
  - S_DATA: set discard, load pc; if rvalid in same cycle, drop data -> S_ADDR directly, discard clear.
  - S_OUT: drop IFU_valid next cycle -> S_ADDR. Redirect wins over a simultaneous IDU_ready handshake (instruction not considered consumed).
- Fault: rresp!=0 captured as IFU_fault=1, IFU_inst=32'h0000_0013; PC advance unchanged. Trap handling is downstream.
- Only one outstanding read at any time.

## Timing
- Reset values: state S_IDLE, pc RESET_PC, discard 0, ifu_arvalid 0, ifu_rready 0, IFU_valid 0, IFU_inst 0, IFU_pc 0, IFU_fault 0.
- ifu_arvalid, ifu_rready, IFU_valid are decoded from registered state only (no combinational path from any input).
- First arvalid: second rising edge after rst deasserts.
- Zero-wait memory (arready=1, rvalid one cycle after acceptance), IDU_ready=1: one instruction per 3 cycles (ADDR, DATA, OUT).
- IFU_valid rises the cycle after the accepted rvalid edge.
- Redirect effect: new address on ifu_araddr no earlier than the cycle after redirect_valid, and only once the in-flight read (if any) has completed.
- Reset asserted mid-transaction: all state returns to reset values immediately; the outstanding memory response is the memory's to cancel on the same reset.

## Structure
- Shared package: fetch state enum, RESP_OKAY constant, NOP_INST constant (32'h0000_0013), default RESET_PC.
- Single module; no sub-module. PC register, state register, discard flag and output registers live in one block.

## Test plan
- Reset release, memory zero-wait, IDU_ready=1 -> araddr sequence 8000_0000, 8000_0004, 8000_0008; IFU_valid every third cycle with matching IFU_pc.
- IDU_ready low 5 cycles in S_OUT -> IFU_inst/IFU_pc stable, no new arvalid; accepted on 6th cycle, next araddr = pc+4.
- redirect_valid with target 8000_0102 while in S_DATA, rvalid 3 cycles later -> data dropped, IFU_valid never asserted for it, next araddr 8000_0100.
- redirect_valid and IDU_ready same cycle in S_OUT -> next araddr = target, not pc+4.
- rresp=2'b10 at pc 8000_0010 -> IFU_fault=1, IFU_inst=0000_0013, next araddr 8000_0014.
- redirect_pc FFFF_FFFC, accept it -> next araddr 0000_0000; rst pulsed mid-S_DATA -> all outputs at reset values asynchronously, restart at 8000_0000.

Source files
------------

// File: rtl/ifu_fetch_ysyx23060136_pkg.sv
// Shared types and constants for the RV32E instruction fetch unit.
package ifu_fetch_ysyx23060136_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifu_fetch_ysyx23060136.sv
// Instruction fetch: one read per instruction, valid/ready toward decode,
// redirects flush the in-flight read and restart at the target.
module ifu_fetch_ysyx23060136
    import ifu_fetch_ysyx23060136_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         ifu_arvalid,
    output logic [31:0]  ifu_araddr,
    input  logic         ifu_arready,
    input  logic         ifu_rvalid,
    input  logic [31:0]  ifu_rdata,
    input  logic [1:0]   ifu_rresp,
    output logic         ifu_rready,
    output logic         IFU_valid,
    output logic [31:0]  IFU_inst,
    output logic [31:0]  IFU_pc,
    output logic         IFU_fault,
    input  logic         IDU_ready,
    output fetch_state_e dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready and stays up, with its payload
    // frozen, until the transfer happens (or a redirect withdraws IFU_valid).

    fetch_state_e state, state_next;
    logic [31:0]  pc;
    logic [31:0]  addr_q;
    logic         discard;
    logic [31:0]  target;

    assign target = word_align(redirect_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_ADDR;
            S_ADDR:  if (ifu_arready) state_next = S_DATA;
            S_DATA:  if (ifu_rvalid) state_next = (discard || redirect_valid) ? S_ADDR : S_OUT;
            S_OUT:   if (redirect_valid || IDU_ready) state_next = S_ADDR;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ifu_arvalid = (state == S_ADDR);
        ifu_rready  = (state == S_DATA);
        IFU_valid   = (state == S_OUT);
        ifu_araddr  = addr_q;
        dbg_state   = state;
    end

    // pc is the next instruction to deliver; addr_q is the address actually
    // presented, which must stay put while a redirect arrives before acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            addr_q    <= RESET_PC;
            discard   <= 1'b0;
            IFU_inst  <= 32'h0;
            IFU_pc    <= 32'h0;
            IFU_fault <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc     <= target;
                        addr_q <= target;
                    end else begin
                        addr_q <= pc;
                    end
                end
                S_ADDR: begin
                    if (redirect_valid) begin
                        pc      <= target;
                        discard <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (ifu_rvalid) begin
                        discard <= 1'b0;
                        if (redirect_valid) begin
                            pc     <= target;
                            addr_q <= target;
                        end else if (discard) begin
                            addr_q <= pc;
                        end else begin
                            IFU_inst  <= (ifu_rresp == RESP_OKAY) ? ifu_rdata : NOP_INST;
                            IFU_pc    <= addr_q;
                            IFU_fault <= (ifu_rresp != RESP_OKAY);
                        end
                    end else if (redirect_valid) begin
                        pc      <= target;
                        discard <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        pc     <= target;
                        addr_q <= target;
                    end else if (IDU_ready) begin
                        pc     <= pc + 32'd4;
                        addr_q <= pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ysyx23060136.sv
// Bench for the fetch unit: a randomized memory model plus a PC-sequence
// reference, with directed scenarios for stalls, redirects, faults and reset.
module tb_ifu_fetch_ysyx23060136;
    import ifu_fetch_ysyx23060136_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         ifu_arvalid;
    logic [31:0]  ifu_araddr;
    logic         ifu_arready;
    logic         ifu_rvalid;
    logic [31:0]  ifu_rdata;
    logic [1:0]   ifu_rresp;
    logic         ifu_rready;
    logic         IFU_valid;
    logic [31:0]  IFU_inst;
    logic [31:0]  IFU_pc;
    logic         IFU_fault;
    logic         IDU_ready;
    fetch_state_e dbg_state;

    ifu_fetch_ysyx23060136 dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rready(ifu_rready),
        .IFU_valid(IFU_valid), .IFU_inst(IFU_inst), .IFU_pc(IFU_pc),
        .IFU_fault(IFU_fault), .IDU_ready(IDU_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents and fault map of the bench memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
    endfunction

    function automatic logic [1:0] mem_resp(input logic [31:0] a);
        return (a[6:0] == 7'h10) ? 2'b10 : 2'b00;
    endfunction

    // Memory model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          rd_min, rd_max, p_arready;

    // Reference: PC of the next instruction decode must receive
    logic [31:0] exp_pc;
    logic [31:0] ar_log[$];
    logic [31:0] exp_q[$];
    int          out_cyc[$];
    int          cyc;

    bit          prev_ar_hold, prev_out_hold;
    logic [31:0] prev_ar_addr, prev_inst, prev_pc;
    logic        prev_fault;

    task automatic step();
        logic r_fire, a_fire;
        ifu_arready = ($urandom_range(99) < p_arready);
        if (mem_busy && mem_wait == 0) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_word(mem_addr);
            ifu_rresp  = mem_resp(mem_addr);
        end else begin
            ifu_rvalid = 1'b0;
            ifu_rdata  = $urandom;
            ifu_rresp  = 2'($urandom_range(3));
        end

        if (prev_ar_hold) begin
            check("ar_hold_valid", ifu_arvalid, 1);
            check("ar_hold_addr", ifu_araddr, prev_ar_addr);
        end
        if (prev_out_hold) begin
            check("out_hold_valid", IFU_valid, 1);
            check("out_hold_inst", IFU_inst, prev_inst);
            check("out_hold_pc", IFU_pc, prev_pc);
            check("out_hold_fault", IFU_fault, prev_fault);
        end
        if (ifu_arvalid) check("araddr_aligned", ifu_araddr[1:0], 0);

        r_fire = ifu_rvalid & ifu_rready;
        a_fire = ifu_arvalid & ifu_arready;
        if (r_fire) mem_busy = 0;
        else if (mem_busy && mem_wait > 0) mem_wait--;
        if (a_fire) begin
            check("one_outstanding", mem_busy, 0);
            mem_busy = 1;
            mem_addr = ifu_araddr;
            mem_wait = $urandom_range(rd_max, rd_min);
            ar_log.push_back(ifu_araddr);
        end

        if (IFU_valid && IDU_ready && !redirect_valid) begin
            check("out_pc", IFU_pc, exp_pc);
            check("out_fault", IFU_fault, mem_resp(exp_pc) != 2'b00);
            check("out_inst", IFU_inst, (mem_resp(exp_pc) != 2'b00) ? NOP_INST : mem_word(exp_pc));
            exp_q.push_back(IFU_pc);
            out_cyc.push_back(cyc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;

        prev_ar_hold  = ifu_arvalid && !ifu_arready;
        prev_ar_addr  = ifu_araddr;
        prev_out_hold = IFU_valid && !IDU_ready && !redirect_valid;
        prev_inst     = IFU_inst;
        prev_pc       = IFU_pc;
        prev_fault    = IFU_fault;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_ar(input int bound);
        int n0;
        int k;
        n0 = ar_log.size();
        k = 0;
        while (ar_log.size() == n0 && k < bound) begin
            step();
            k++;
        end
        if (ar_log.size() == n0) check("timeout_ar", 0, 1);
    endtask

    task automatic wait_valid(input int bound);
        int k;
        k = 0;
        IDU_ready = 1'b0;
        while (!IFU_valid && k < bound) begin
            step();
            k++;
        end
        if (!IFU_valid) check("timeout_valid", 0, 1);
    endtask

    task automatic redirect_step(input logic [31:0] tgt, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        IDU_ready      = rdy;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arvalid"}, ifu_arvalid, 0);
        check({tag, "_rready"}, ifu_rready, 0);
        check({tag, "_valid"}, IFU_valid, 0);
        check({tag, "_inst"}, IFU_inst, 0);
        check({tag, "_pc"}, IFU_pc, 0);
        check({tag, "_fault"}, IFU_fault, 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        logic [31:0] pc_hold;
        int          n_out;
        rst = 1'b1;
        redirect_valid = 0; redirect_pc = 0; ifu_arready = 0; ifu_rvalid = 0;
        ifu_rdata = 0; ifu_rresp = 0; IDU_ready = 0;
        mem_busy = 0; mem_wait = 0; mem_addr = 0; cyc = 0;
        prev_ar_hold = 0; prev_out_hold = 0; exp_pc = RST_PC;
        p_arready = 100; rd_min = 0; rd_max = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        check("idle_no_ar", ifu_arvalid, 0);

        // Zero-wait memory, decode always ready
        IDU_ready = 1'b1;
        step();
        check("first_arvalid", ifu_arvalid, 1);
        repeat (9) step();
        check("seq_ar0", ar_log[0], 32'h8000_0000);
        check("seq_ar1", ar_log[1], 32'h8000_0004);
        check("seq_ar2", ar_log[2], 32'h8000_0008);
        check("seq_out0", exp_q[0], 32'h8000_0000);
        check("seq_out1", exp_q[1], 32'h8000_0004);
        check("issue_rate", out_cyc[1] - out_cyc[0], 3);

        // Decode stalls five cycles in S_OUT
        wait_valid(50);
        pc_hold = IFU_pc;
        repeat (5) begin
            check("stall_no_ar", ifu_arvalid, 0);
            step();
        end
        check("stall_pc", IFU_pc, pc_hold);
        IDU_ready = 1'b1;
        step();
        run_until_ar(50);
        check("stall_next_ar", ar_log[$], pc_hold + 32'd4);

        // Redirect while the read is in flight; data arrives three cycles later
        rd_min = 3; rd_max = 3;
        run_until_ar(50);
        n_out = exp_q.size();
        redirect_step(32'h8000_0102, 1'b1);
        run_until_ar(50);
        check("flush_next_ar", ar_log[$], 32'h8000_0100);
        check("flush_no_out", exp_q.size(), n_out);
        rd_min = 0; rd_max = 0;
        wait_valid(50);
        check("flush_first_pc", IFU_pc, 32'h8000_0100);

        // Redirect beats a simultaneous decode handshake
        redirect_step(32'h8000_0200, 1'b1);
        run_until_ar(50);
        check("redir_vs_ready", ar_log[$], 32'h8000_0200);

        // Access fault at 8000_0010
        wait_valid(50);
        redirect_step(32'h8000_0010, 1'b0);
        wait_valid(50);
        check("fault_flag", IFU_fault, 1);
        check("fault_inst", IFU_inst, NOP_INST);
        check("fault_pc", IFU_pc, 32'h8000_0010);
        IDU_ready = 1'b1;
        step();
        run_until_ar(50);
        check("fault_next_ar", ar_log[$], 32'h8000_0014);

        // PC wraps at the top of the address space
        wait_valid(50);
        redirect_step(32'hFFFF_FFFC, 1'b0);
        wait_valid(50);
        check("wrap_pc", IFU_pc, 32'hFFFF_FFFC);
        IDU_ready = 1'b1;
        step();
        run_until_ar(50);
        check("wrap_next_ar", ar_log[$], 32'h0000_0000);

        // Randomized traffic
        p_arready = 60; rd_min = 0; rd_max = 4;
        n_out = exp_q.size();
        repeat (1500) begin
            IDU_ready      = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : $urandom;
            step();
        end
        redirect_valid = 1'b0;
        check("random_progress", exp_q.size() > n_out, 1);

        // Asynchronous reset in the middle of a read
        p_arready = 100; rd_min = 5; rd_max = 5; IDU_ready = 1'b1;
        run_until_ar(50);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        mem_busy = 0; ifu_rvalid = 0; exp_pc = RST_PC;
        prev_ar_hold = 0; prev_out_hold = 0;
        rd_min = 0; rd_max = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_until_ar(20);
        check("post_rst_ar", ar_log[$], RST_PC);
        wait_valid(20);
        check("post_rst_pc", IFU_pc, RST_PC);
        IDU_ready = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
